ravan_job_sequencer: RTL and testbench
======================================

// Module: ravan_job_sequencer
// PURPOSE
//  Upstream command stage for the RAVAN AXI-style crypto wrapper. Accepts one
//  encryption job (data, key, address, mem_sel) on a valid/ready interface and
//  drives the wrapper's write, response, read-address and read handshakes in order.
//  Captures the 64-bit result and returns it on a valid/ready result port.
//  Any handshake phase that stalls is aborted by a per-phase watchdog.
// PARAMETERS
//  TIMEOUT   64  max cycles spent in any one handshake phase before abort (>=4)
//  CNT_W     7   watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk          in   1    clock
//  rst          in   1    reset, asynchronous, active-low
//  job_valid    in   1    job offered
//  job_ready    out  1    sequencer idle, job accepted when valid&ready
//  job_data     in   64   plaintext/ciphertext word
//  job_key      in   512  key
//  job_addr     in   32   target address
//  job_mem_sel  in   1    memory select, held stable to engine for whole job
//  res_valid    out  1    result available
//  res_ready    in   1    result consumed when valid&ready
//  res_data     out  64   engine output word
//  res_err      out  1    1 = job aborted by watchdog (res_data = 0)
//  eng_data     out  64   registered job_data to engine
//  eng_key      out  512  registered job_key to engine
//  eng_addr     out  32   registered job_addr to engine
//  eng_mem_sel  out  1    registered job_mem_sel to engine
//  eng_awvalid, eng_wvalid, eng_bready, eng_arvalid, eng_rready  out 1 each
//  eng_awready, eng_wready, eng_bvalid, eng_arready, eng_rvalid  in  1 each
//  eng_dout     in   64   engine data_out (registered inside engine)
// BEHAVIOUR
//  Reset: all outputs 0 except job_ready=1; state IDLE; watchdog 0.
//  States: IDLE->AW->W->B->AR->R->CAP->RES->IDLE.
//  IDLE: job_ready=1. On job_valid: latch job into eng_* regs, goto AW next cycle.
//  AW: eng_awvalid=1 until eng_awready sampled 1; then goto W.
//  W:  eng_wvalid=1 until eng_wready sampled 1; then goto B.
//  B:  eng_bready=0 until eng_bvalid sampled 1; then eng_bready=1 exactly one
//      cycle, goto AR. bready never asserted before bvalid seen.
//  AR: eng_arvalid=1 until eng_arready sampled 1; then goto R.
//  R:  eng_rready=0 until eng_rvalid sampled 1; then eng_rready=1 one cycle, goto CAP.
//  CAP: wait one cycle (engine registers dout on rready edge), then
//      res_data<=eng_dout, res_err<=0, res_valid<=1, goto RES.
//  RES: hold res_valid/res_data/res_err until res_ready; then clear res_valid,
//      goto IDLE. Min job latency: accept to res_valid = 9 cycles + engine waits.
//  Watchdog: cleared on each state change; increments in AW,W,B,AR,R. When it
//      reaches TIMEOUT: drop all eng_* valid/ready, res_data=0, res_err=1,
//      res_valid=1, goto RES. Counter saturates, no wrap.
//  eng_data/key/addr/mem_sel change only on job acceptance.
//  Valid outputs are registered; deassert same edge the matching ready is sampled.
//  New job never accepted while res_valid=1 (no result overwrite).
//  rst low mid-job: immediate return to reset values; partial job discarded.
// STRUCTURE
//  Shared package ravan_pkg: state encoding localparams (3-bit), TIMEOUT default,
//  job/result field widths (64/512/32). One natural sub-module:
//  ravan_phase_watchdog (clear, enable, count, expired) instantiated once.
// TESTING
//  1 Single job, engine model replies in 1 cycle per phase, dout=64'hDEAD_BEEF_0123_4567
//    -> res_valid with that data, res_err=0, eng_addr=job_addr throughout.
//  2 Engine delays bvalid 5 cycles -> eng_bready stays 0 for those 5 cycles, then
//    pulses exactly 1 cycle.
//  3 Engine never asserts arready, TIMEOUT=64 -> after 64 cycles in AR, res_err=1,
//    res_data=0, eng_arvalid=0.
//  4 res_ready held 0 for 10 cycles with job_valid=1 -> job_ready=0, res_data stable;
//    on res_ready, second job accepted 1 cycle later.
//  5 Back-to-back 3 jobs, keys 512'h1/2/3 -> 3 results in order, no lost/duplicated.
//  6 rst asserted in W state -> all outputs reset values same cycle, job_ready=1
//    after release, next job completes normally.

Source files
------------

// File: rtl/ravan_pkg.sv
// rtl/ravan_pkg.sv - shared widths, defaults and state encoding for the RAVAN job sequencer
package ravan_pkg;

    localparam int DATA_W      = 64;
    localparam int KEY_W       = 512;
    localparam int ADDR_W      = 32;
    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF   = 7;

    // One state per wrapper handshake phase, plus capture and result hold.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_CAP  = 3'd6,
        ST_RES  = 3'd7
    } seq_state_t;

    // Phases in which the engine can stall us and the watchdog must run.
    function automatic logic is_handshake_phase(input seq_state_t s);
        return (s == ST_AW) || (s == ST_W) || (s == ST_B) || (s == ST_AR) || (s == ST_R);
    endfunction

endpackage

// File: rtl/ravan_job_sequencer_if.sv
// rtl/ravan_job_sequencer_if.sv - job, result and engine handshake bundle
// Ports (slave = sequencer view):
//   job_valid/job_ready + job_data/key/addr/mem_sel : job offered by upstream
//   res_valid/res_ready + res_data/res_err          : result returned upstream
//   eng_data/key/addr/mem_sel                       : registered job fields to engine
//   eng_aw/w/ar valid, eng_b/r ready                : sequencer-driven handshakes
//   eng_aw/w/ar ready, eng_b/r valid, eng_dout      : engine-driven handshakes and data
interface ravan_job_sequencer_if;
    import ravan_pkg::*;

    logic              job_valid;
    logic              job_ready;
    logic [DATA_W-1:0] job_data;
    logic [KEY_W-1:0]  job_key;
    logic [ADDR_W-1:0] job_addr;
    logic              job_mem_sel;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_err;

    logic [DATA_W-1:0] eng_data;
    logic [KEY_W-1:0]  eng_key;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_mem_sel;
    logic              eng_awvalid, eng_wvalid, eng_bready, eng_arvalid, eng_rready;
    logic              eng_awready, eng_wready, eng_bvalid, eng_arready, eng_rvalid;
    logic [DATA_W-1:0] eng_dout;

    modport slave (
        input  job_valid, job_data, job_key, job_addr, job_mem_sel, res_ready,
               eng_awready, eng_wready, eng_bvalid, eng_arready, eng_rvalid, eng_dout,
        output job_ready, res_valid, res_data, res_err,
               eng_data, eng_key, eng_addr, eng_mem_sel,
               eng_awvalid, eng_wvalid, eng_bready, eng_arvalid, eng_rready
    );

    modport master (
        output job_valid, job_data, job_key, job_addr, job_mem_sel, res_ready,
               eng_awready, eng_wready, eng_bvalid, eng_arready, eng_rvalid, eng_dout,
        input  job_ready, res_valid, res_data, res_err,
               eng_data, eng_key, eng_addr, eng_mem_sel,
               eng_awvalid, eng_wvalid, eng_bready, eng_arvalid, eng_rready
    );

endinterface

// File: rtl/ravan_phase_watchdog.sv
// rtl/ravan_phase_watchdog.sv - per-phase stall counter with saturating count
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : restart the count (asserted on every state change)
//   enable    : count this cycle
//   expired   : this cycle is the TIMEOUT-th one spent in the phase
module ravan_phase_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(TIMEOUT))) begin
            count <= count + CNT_W'(1);
        end
    end

    // Fires on the cycle whose closing edge would bring the count to TIMEOUT,
    // so a stalled phase occupies exactly TIMEOUT cycles before the abort edge.
    assign expired = enable && (count >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ravan_job_sequencer.sv
// rtl/ravan_job_sequencer.sv - sequences one crypto job through the wrapper handshakes
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   bus      : ravan_job_sequencer_if.slave (job in, result out, engine handshakes)
module ravan_job_sequencer
    import ravan_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    ravan_job_sequencer_if.slave  bus
);

    seq_state_t        state, state_nxt;
    logic              ack, ack_nxt;       // B/R: one-cycle ready pulse after valid was seen
    logic              bready_nxt, rready_nxt;
    logic              res_valid_nxt, res_err_nxt;
    logic [DATA_W-1:0] res_data_nxt;
    logic              accept;
    logic              wd_clear, wd_enable, wd_expired;

    assign accept    = (state == ST_IDLE) && bus.job_valid;
    assign wd_enable = is_handshake_phase(state) && !ack;
    assign wd_clear  = (state_nxt != state);

    ravan_phase_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_nxt     = state;
        ack_nxt       = 1'b0;
        bready_nxt    = 1'b0;
        rready_nxt    = 1'b0;
        res_valid_nxt = bus.res_valid;
        res_err_nxt   = bus.res_err;
        res_data_nxt  = bus.res_data;

        case (state)
            ST_IDLE: if (bus.job_valid) state_nxt = ST_AW;
            ST_AW:   if (bus.eng_awready) state_nxt = ST_W;
            ST_W:    if (bus.eng_wready) state_nxt = ST_B;
            ST_B: begin
                if (ack) begin
                    state_nxt = ST_AR;
                end else if (bus.eng_bvalid) begin
                    ack_nxt    = 1'b1;
                    bready_nxt = 1'b1;
                end
            end
            ST_AR:   if (bus.eng_arready) state_nxt = ST_R;
            ST_R: begin
                if (ack) begin
                    state_nxt = ST_CAP;
                end else if (bus.eng_rvalid) begin
                    ack_nxt    = 1'b1;
                    rready_nxt = 1'b1;
                end
            end
            // Engine updates dout on the rready edge, so sample it one cycle later.
            ST_CAP: begin
                state_nxt     = ST_RES;
                res_valid_nxt = 1'b1;
                res_err_nxt   = 1'b0;
                res_data_nxt  = bus.eng_dout;
            end
            ST_RES: begin
                if (bus.res_ready) begin
                    state_nxt     = ST_IDLE;
                    res_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort overrides any handshake completing on the same edge.
        if (wd_expired) begin
            state_nxt     = ST_RES;
            ack_nxt       = 1'b0;
            bready_nxt    = 1'b0;
            rready_nxt    = 1'b0;
            res_valid_nxt = 1'b1;
            res_err_nxt   = 1'b1;
            res_data_nxt  = '0;
        end
    end

    // Handshake outputs are registered copies of the next state, so each valid
    // drops on the same edge at which its ready is sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            ack             <= 1'b0;
            bus.job_ready   <= 1'b1;
            bus.res_valid   <= 1'b0;
            bus.res_err     <= 1'b0;
            bus.res_data    <= '0;
            bus.eng_awvalid <= 1'b0;
            bus.eng_wvalid  <= 1'b0;
            bus.eng_bready  <= 1'b0;
            bus.eng_arvalid <= 1'b0;
            bus.eng_rready  <= 1'b0;
            bus.eng_data    <= '0;
            bus.eng_key     <= '0;
            bus.eng_addr    <= '0;
            bus.eng_mem_sel <= 1'b0;
        end else begin
            state           <= state_nxt;
            ack             <= ack_nxt;
            bus.job_ready   <= (state_nxt == ST_IDLE);
            bus.res_valid   <= res_valid_nxt;
            bus.res_err     <= res_err_nxt;
            bus.res_data    <= res_data_nxt;
            bus.eng_awvalid <= (state_nxt == ST_AW);
            bus.eng_wvalid  <= (state_nxt == ST_W);
            bus.eng_bready  <= bready_nxt;
            bus.eng_arvalid <= (state_nxt == ST_AR);
            bus.eng_rready  <= rready_nxt;
            if (accept) begin
                bus.eng_data    <= bus.job_data;
                bus.eng_key     <= bus.job_key;
                bus.eng_addr    <= bus.job_addr;
                bus.eng_mem_sel <= bus.job_mem_sel;
            end
        end
    end

endmodule

// File: tb/tb_ravan_job_sequencer.sv
// tb/tb_ravan_job_sequencer.sv - self-checking bench for ravan_job_sequencer
module tb_ravan_job_sequencer;
    import ravan_pkg::*;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ravan_job_sequencer_if bus();

    ravan_job_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine transfer function: what the wrapper returns for a given job.
    function automatic logic [63:0] eng_fn(input logic [63:0] d, input logic [511:0] k,
                                           input logic [31:0] a, input logic m);
        return d ^ k[63:0] ^ k[511:448] ^ {a, 31'd0, m};
    endfunction

    // Engine responder controls (written by the main thread)
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          stall_w = 0, stall_ar = 0;
    bit          fixed_en = 0;
    logic [63:0] fixed_dout = '0;
    // Responder observations (written by the responder only)
    int          bready_hi = 0, rready_hi = 0;
    bit          bready_early = 0, rready_early = 0;

    // Engine responder: acts on the falling edge, away from the DUT's sampling edge.
    initial begin
        int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit  b_pend, b_drop, r_pend, r_drop;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        b_pend = 0; b_drop = 0; r_pend = 0; r_drop = 0;
        bus.eng_awready = 0; bus.eng_wready = 0; bus.eng_bvalid = 0;
        bus.eng_arready = 0; bus.eng_rvalid = 0; bus.eng_dout = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                b_pend = 0; b_drop = 0; r_pend = 0; r_drop = 0;
                bus.eng_awready = 0; bus.eng_wready = 0; bus.eng_bvalid = 0;
                bus.eng_arready = 0; bus.eng_rvalid = 0; bus.eng_dout = '0;
            end else begin
                if (bus.eng_bready) begin bready_hi++; if (!bus.eng_bvalid) bready_early = 1; end
                if (bus.eng_rready) begin rready_hi++; if (!bus.eng_rvalid) rready_early = 1; end
                // AW
                if (bus.eng_awready) bus.eng_awready = 0;
                else if (bus.eng_awvalid) begin
                    if (aw_cnt >= aw_dly) begin
                        bus.eng_awready = 1; aw_cnt = 0;
                        bready_hi = 0; rready_hi = 0; bready_early = 0; rready_early = 0;
                    end else aw_cnt++;
                end
                // W
                if (bus.eng_wready) begin bus.eng_wready = 0; b_pend = 1; end
                else if (bus.eng_wvalid && !stall_w) begin
                    if (w_cnt >= w_dly) begin bus.eng_wready = 1; w_cnt = 0; end else w_cnt++;
                end
                // B
                if (b_drop) begin bus.eng_bvalid = 0; b_drop = 0; end
                else if (bus.eng_bvalid && bus.eng_bready) b_drop = 1;
                else if (b_pend && !bus.eng_bvalid) begin
                    if (b_cnt >= b_dly) begin bus.eng_bvalid = 1; b_pend = 0; b_cnt = 0; end else b_cnt++;
                end
                // AR
                if (bus.eng_arready) begin bus.eng_arready = 0; r_pend = 1; end
                else if (bus.eng_arvalid && !stall_ar) begin
                    if (ar_cnt >= ar_dly) begin bus.eng_arready = 1; ar_cnt = 0; end else ar_cnt++;
                end
                // R: dout updates after the rready handshake edge
                if (r_drop) begin
                    bus.eng_rvalid = 0; r_drop = 0;
                    bus.eng_dout = fixed_en ? fixed_dout
                                 : eng_fn(bus.eng_data, bus.eng_key, bus.eng_addr, bus.eng_mem_sel);
                end
                else if (bus.eng_rvalid && bus.eng_rready) r_drop = 1;
                else if (r_pend && !bus.eng_rvalid) begin
                    if (r_cnt >= r_dly) begin bus.eng_rvalid = 1; r_pend = 0; r_cnt = 0; end else r_cnt++;
                end
            end
        end
    end

    // Scoreboard of expected results, in acceptance order
    logic [63:0]  exp_q[$];
    logic [511:0] key_q[$];
    logic [31:0]  addr_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_job(input logic [63:0] d, input logic [511:0] k,
                            input logic [31:0] a, input logic m);
        bit ok;
        ok = 0;
        bus.job_data = d; bus.job_key = k; bus.job_addr = a; bus.job_mem_sel = m;
        bus.job_valid = 1;
        for (int i = 0; i < 200; i++) begin
            if (bus.job_ready) begin tick(); ok = 1; break; end
            tick();
        end
        bus.job_valid = 0;
        check("job_accept_bound", ok, 1);
    endtask

    task automatic wait_result();
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (bus.res_valid) begin ok = 1; break; end
            tick();
        end
        check("res_valid_bound", ok, 1);
    endtask

    task automatic consume();
        bus.res_ready = 1;
        tick();
        bus.res_ready = 0;
        check("res_valid_cleared", bus.res_valid, 0);
    endtask

    task automatic check_result();
        logic [63:0]  e;
        logic [511:0] k;
        logic [31:0]  a;
        e = exp_q.pop_front(); k = key_q.pop_front(); a = addr_q.pop_front();
        check("res_data", bus.res_data, e);
        check("res_err", bus.res_err, 0);
        check("eng_addr", bus.eng_addr, a);
        check("eng_key", bus.eng_key, k);
        check("bready_pulse", bready_hi, 1);
        check("bready_early", bready_early, 0);
        check("rready_pulse", rready_hi, 1);
        check("rready_early", rready_early, 0);
    endtask

    task automatic run_job(input logic [63:0] d, input logic [511:0] k, input logic [31:0] a,
                           input logic m, input int hold);
        exp_q.push_back(fixed_en ? fixed_dout : eng_fn(d, k, a, m));
        key_q.push_back(k);
        addr_q.push_back(a);
        send_job(d, k, a, m);
        check("eng_addr_at_accept", bus.eng_addr, a);
        wait_result();
        check_result();
        for (int h = 0; h < hold; h++) begin
            tick();
            check("res_hold_valid", bus.res_valid, 1);
        end
        consume();
    endtask

    function automatic logic [511:0] rand_key();
        logic [511:0] k;
        for (int i = 0; i < 16; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] dat_a, dat_b;
        int          n;
        bit          ok;
        bus.job_valid = 0; bus.job_data = '0; bus.job_key = '0; bus.job_addr = '0;
        bus.job_mem_sel = 0; bus.res_ready = 0;
        rst = 0;
        repeat (3) tick();
        // Reset state
        check("rst_job_ready", bus.job_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_err", bus.res_err, 0);
        check("rst_handshakes", {bus.eng_awvalid, bus.eng_wvalid, bus.eng_bready,
                                 bus.eng_arvalid, bus.eng_rready}, 0);
        check("rst_eng_data", bus.eng_data, 0);
        rst = 1;
        tick();

        // 1: single job, fast engine, fixed dout
        fixed_en = 1; fixed_dout = 64'hDEAD_BEEF_0123_4567;
        run_job(64'h1111_2222_3333_4444, 512'hABCD, 32'h8000_0010, 1'b1, 0);
        fixed_en = 0;

        // 2: bvalid delayed 5 cycles
        b_dly = 5;
        run_job(64'h5555_6666_7777_8888, rand_key(), 32'h0000_0200, 1'b0, 0);
        b_dly = 0;

        // 3: arready never comes -> watchdog abort after TIMEOUT cycles in AR
        stall_ar = 1;
        send_job(64'h9999, 512'h77, 32'h300, 1'b0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.eng_arvalid) begin ok = 1; break; end
            tick();
        end
        check("ar_reached", ok, 1);
        n = 0;
        while (bus.eng_arvalid && n < 200) begin n++; tick(); end
        check("ar_cycles", n, TIMEOUT);
        check("abort_res_valid", bus.res_valid, 1);
        check("abort_res_err", bus.res_err, 1);
        check("abort_res_data", bus.res_data, 0);
        check("abort_handshakes", {bus.eng_awvalid, bus.eng_wvalid, bus.eng_bready,
                                   bus.eng_arvalid, bus.eng_rready}, 0);
        consume();
        stall_ar = 0;

        // 4: result held 10 cycles while next job waits
        dat_a = 64'hA0A0_A0A0_0000_0001;
        dat_b = 64'hB0B0_B0B0_0000_0002;
        exp_q.push_back(eng_fn(dat_a, 512'h4, 32'h400, 1'b0));
        key_q.push_back(512'h4); addr_q.push_back(32'h400);
        send_job(dat_a, 512'h4, 32'h400, 1'b0);
        wait_result();
        check_result();
        bus.job_data = dat_b; bus.job_key = 512'h5; bus.job_addr = 32'h500; bus.job_mem_sel = 1;
        bus.job_valid = 1;
        for (int i = 0; i < 10; i++) begin
            check("hold_job_ready", bus.job_ready, 0);
            check("hold_res_data", bus.res_data, eng_fn(dat_a, 512'h4, 32'h400, 1'b0));
            tick();
        end
        bus.res_ready = 1;
        tick();
        bus.res_ready = 0;
        check("release_job_ready", bus.job_ready, 1);
        check("release_res_valid", bus.res_valid, 0);
        tick();
        bus.job_valid = 0;
        check("second_accepted", bus.job_ready, 0);
        check("second_eng_data", bus.eng_data, dat_b);
        exp_q.push_back(eng_fn(dat_b, 512'h5, 32'h500, 1'b1));
        key_q.push_back(512'h5); addr_q.push_back(32'h500);
        wait_result();
        check_result();
        consume();

        // 5: three back-to-back jobs, keys 1/2/3
        for (int j = 1; j <= 3; j++)
            run_job(64'hC000 + 64'(j), 512'(j), 32'h600 + 32'(j), j[0], 0);
        check("scoreboard_empty", exp_q.size(), 0);

        // 6: reset asserted while in W
        stall_w = 1;
        send_job(64'hD00D, 512'h6, 32'h700, 1'b1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.eng_wvalid) begin ok = 1; break; end
            tick();
        end
        check("w_reached", ok, 1);
        tick();
        rst = 0;
        #1;
        check("midrst_job_ready", bus.job_ready, 1);
        check("midrst_handshakes", {bus.eng_awvalid, bus.eng_wvalid, bus.eng_bready,
                                    bus.eng_arvalid, bus.eng_rready}, 0);
        check("midrst_eng_fields", {bus.eng_data, bus.eng_addr, bus.eng_mem_sel}, 0);
        check("midrst_eng_key", bus.eng_key, 0);
        check("midrst_res_valid", bus.res_valid, 0);
        repeat (2) tick();
        rst = 1;
        stall_w = 0;
        tick();
        check("post_rst_job_ready", bus.job_ready, 1);
        run_job(64'hE0E0_0000_1234_5678, rand_key(), 32'h800, 1'b0, 1);

        // Randomized jobs with random engine delays and result back-pressure
        for (int j = 0; j < 20; j++) begin
            aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4);
            b_dly  = $urandom_range(0, 4); ar_dly = $urandom_range(0, 4);
            r_dly  = $urandom_range(0, 4);
            run_job({$urandom, $urandom}, rand_key(), $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3));
        end
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
